// File: rtl/iter_partial_product_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Optional feature macro: PP_SIGNED_EN (enables two's complement operands).
package pp_mult_pkg;

    // Controller states: waiting for operands, retiring slices, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pp_state_t;

    // Width of the slice counter for n slices; never narrower than one bit.
    function automatic int pp_count_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iter_partial_product_if.sv
// Operand/result handshake bundle for iter_partial_product.
// Optional feature macro: PP_SIGNED_EN adds the SIGNED_MODE signal.
//
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both high. The producer holds its data stable while VALID is high and
// READY is low; READY never depends combinationally on VALID.
interface iter_partial_product_if #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
);
    import pp_mult_pkg::*;

    logic                       IN_VALID;
    logic                       IN_READY;
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B;
`ifdef PP_SIGNED_EN
    logic                       SIGNED_MODE;
`endif
    logic                       OUT_VALID;
    logic                       OUT_READY;
    logic [A_WIDTH+B_WIDTH-1:0] P;
    logic                       BUSY;
    pp_state_t                  STATE;      // debug view of the controller

    // Operand producer / result consumer side.
    modport master (
        output IN_VALID,
        output A,
        output B,
        output OUT_READY,
`ifdef PP_SIGNED_EN
        output SIGNED_MODE,
`endif
        input  IN_READY,
        input  OUT_VALID,
        input  P,
        input  BUSY,
        input  STATE
    );

    // Multiplier side.
    modport slave (
        input  IN_VALID,
        input  A,
        input  B,
        input  OUT_READY,
`ifdef PP_SIGNED_EN
        input  SIGNED_MODE,
`endif
        output IN_READY,
        output OUT_VALID,
        output P,
        output BUSY,
        output STATE
    );

endinterface

// File: rtl/iter_partial_product_slice.sv
// Combinational product of the multiplicand magnitude and one R-bit slice
// of the multiplier, built as a sum of AND-masked shifted copies of A.
module pp_slice #(
    parameter int A_WIDTH = 8,
    parameter int R       = 2
) (
    input  logic [A_WIDTH-1:0]   a_i,
    input  logic [R-1:0]         b_i,
    output logic [A_WIDTH+R-1:0] p_o
);
    localparam int SW = A_WIDTH + R;

    // Accumulate one masked, shifted copy of A per multiplier bit.
    always_comb begin
        p_o = '0;
        for (int j = 0; j < R; j++) begin
            p_o = p_o + (SW'(a_i & {A_WIDTH{b_i[j]}}) << j);
        end
    end

endmodule

// File: rtl/iter_partial_product.sv
// Sequential shift-add multiplier retiring BITS_PER_CYCLE multiplier bits
// per clock, with valid/ready handshakes on operands and result.
// Optional feature macro: PP_SIGNED_EN (two's complement operands selected
// per operation by SIGNED_MODE; sign-magnitude conversion at accept and
// conditional negation on the last RUN cycle).
module iter_partial_product
    import pp_mult_pkg::*;
#(
    parameter int A_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    iter_partial_product_if.slave bus
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int R  = BITS_PER_CYCLE;
    localparam int N  = B_WIDTH / BITS_PER_CYCLE;
    localparam int CW = pp_count_w(N);

    generate
        if ((B_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("BITS_PER_CYCLE must divide B_WIDTH");
        end
    endgenerate

    pp_state_t          state_q, state_d;
    logic [A_WIDTH-1:0] a_mag_q, a_mag_d;
    logic [B_WIDTH-1:0] b_mag_q, b_mag_d;   // shifted right R bits per cycle
    logic [PW-1:0]      acc_q,   acc_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [PW-1:0]      p_q,     p_d;
`ifdef PP_SIGNED_EN
    logic               neg_q,   neg_d;
    logic               sign_a,  sign_b;
`endif

    logic [A_WIDTH+R-1:0] slice;
    logic [PW-1:0]        slice_shifted;
    logic [PW-1:0]        sum;

    // The low R bits of the shifted multiplier are always the current slice.
    pp_slice #(
        .A_WIDTH (A_WIDTH),
        .R       (R)
    ) u_slice (
        .a_i (a_mag_q),
        .b_i (b_mag_q[R-1:0]),
        .p_o (slice)
    );

    // Align the slice product to its weight and add it to the running sum.
    always_comb begin
        slice_shifted = PW'(slice) << (int'(cnt_q) * R);
        sum           = acc_q + slice_shifted;
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
`ifdef PP_SIGNED_EN
        neg_d   = neg_q;
        sign_a  = bus.SIGNED_MODE & bus.A[A_WIDTH-1];
        sign_b  = bus.SIGNED_MODE & bus.B[B_WIDTH-1];
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
`ifdef PP_SIGNED_EN
                    // Most negative value negates to itself, which reads
                    // correctly as an unsigned magnitude.
                    a_mag_d = sign_a ? -bus.A : bus.A;
                    b_mag_d = sign_b ? -bus.B : bus.B;
                    neg_d   = sign_a ^ sign_b;
`else
                    a_mag_d = bus.A;
                    b_mag_d = bus.B;
`endif
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum;
                b_mag_d = b_mag_q >> R;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
`ifdef PP_SIGNED_EN
                    p_d = neg_q ? -sum : sum;
`else
                    p_d = sum;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
`ifdef PP_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
`ifdef PP_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    // Handshake and status outputs decode the state register only.
    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.BUSY      = (state_q == RUN);
    assign bus.P         = p_q;
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_iter_partial_product.sv
// Self-checking bench for iter_partial_product: table-driven products on the
// default configuration, hand-written backpressure / operand-change /
// reset-abort sequences, and a random sweep over BITS_PER_CYCLE = 1, 4, 8
// with a 12x8 multiplier.
module tb_iter_partial_product;
    import pp_mult_pkg::*;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] p;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int sweep_finished = 0;

    logic CLK = 1'b0;
    logic RST_N;
    logic sw_rst_n;

    logic [15:0] exp_q[$];

    // Clock and reset.
    always #5 CLK = ~CLK;

    iter_partial_product_if #(.A_WIDTH(8), .B_WIDTH(8)) bus ();

    iter_partial_product #(
        .A_WIDTH        (8),
        .B_WIDTH        (8),
        .BITS_PER_CYCLE (2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: present one operand pair, push the expected product, and
    // return on the falling edge right after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic [15:0] e);
        @(negedge CLK);
        check("in_ready_before_accept", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID = 1'b1;
        bus.A        = a;
        bus.B        = b;
`ifdef PP_SIGNED_EN
        bus.SIGNED_MODE = sm;
`else
        if (sm) $display("note: signed vector issued in unsigned build");
`endif
        exp_q.push_back(e);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        check("busy_after_accept", 32'(bus.BUSY), 32'd1);
    endtask

    // Wait (bounded) for OUT_VALID, check latency and the scoreboard head.
    task automatic wait_done(input int lat);
        int c;
        c = 0;
        while (!bus.OUT_VALID && c < 64) begin
            @(negedge CLK);
            c++;
        end
        check("latency", 32'(c), 32'(lat));
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            check("product", 32'(bus.P), 32'(exp_q.pop_front()));
        end
    endtask

    // Consume the result and confirm the return to IDLE.
    task automatic release_result();
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        check("out_valid_after_take", 32'(bus.OUT_VALID), 32'd0);
        check("in_ready_after_take", 32'(bus.IN_READY), 32'd1);
    endtask

    // Main sequence.
    initial begin
        vec_t tbl[$];
        int   guard;

        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
`ifdef PP_SIGNED_EN
        bus.SIGNED_MODE = 1'b0;
`endif
        RST_N    = 1'b0;
        sw_rst_n = 1'b0;
        repeat (3) @(negedge CLK);

        check("reset_p", 32'(bus.P), 32'd0);
        check("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_in_ready", 32'(bus.IN_READY), 32'd1);
        check("reset_state", 32'(bus.STATE), 32'(IDLE));

        RST_N    = 1'b1;
        sw_rst_n = 1'b1;

        tbl.push_back('{a: 8'hFF, b: 8'hFF, sm: 1'b0, p: 16'hFE01});
        tbl.push_back('{a: 8'h00, b: 8'h5A, sm: 1'b0, p: 16'h0000});
        tbl.push_back('{a: 8'h01, b: 8'h01, sm: 1'b0, p: 16'h0001});
        tbl.push_back('{a: 8'h12, b: 8'h34, sm: 1'b0, p: 16'h03A8});
        tbl.push_back('{a: 8'h80, b: 8'h80, sm: 1'b0, p: 16'h4000});
        tbl.push_back('{a: 8'hFF, b: 8'h01, sm: 1'b0, p: 16'h00FF});
        tbl.push_back('{a: 8'h0D, b: 8'hC0, sm: 1'b0, p: 16'h09C0});
`ifdef PP_SIGNED_EN
        tbl.push_back('{a: 8'h80, b: 8'h80, sm: 1'b1, p: 16'h4000});
        tbl.push_back('{a: 8'h80, b: 8'h01, sm: 1'b1, p: 16'hFF80});
        tbl.push_back('{a: 8'h05, b: 8'hFD, sm: 1'b1, p: 16'hFFF1});
        tbl.push_back('{a: 8'hFF, b: 8'hFF, sm: 1'b1, p: 16'h0001});
        tbl.push_back('{a: 8'h7F, b: 8'h80, sm: 1'b1, p: 16'hC080});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].p);
            wait_done(4);
            release_result();
        end

        // Backpressure: result held, second request ignored.
        issue(8'h21, 8'h13, 1'b0, 16'h0273);
        wait_done(4);
        bus.IN_VALID = 1'b1;
        bus.A        = 8'h11;
        bus.B        = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stall_p_stable", 32'(bus.P), 32'h0273);
            check("stall_in_ready", 32'(bus.IN_READY), 32'd0);
            check("stall_out_valid", 32'(bus.OUT_VALID), 32'd1);
        end
        bus.IN_VALID = 1'b0;
        release_result();
        check("idle_after_release", 32'(bus.STATE), 32'(IDLE));
        check("p_kept_in_idle", 32'(bus.P), 32'h0273);

        // Operand change while running has no effect.
        issue(8'd3, 8'd7, 1'b0, 16'd21);
        bus.A = 8'hAA;
        bus.B = 8'h55;
`ifdef PP_SIGNED_EN
        bus.SIGNED_MODE = 1'b1;
`endif
        wait_done(4);
        release_result();
`ifdef PP_SIGNED_EN
        bus.SIGNED_MODE = 1'b0;
`endif

        // Reset while RUN is on its third slice.
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.A        = 8'd9;
        bus.B        = 8'd9;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("busy_mid_run", 32'(bus.BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("abort_p", 32'(bus.P), 32'd0);
        check("abort_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_in_ready", 32'(bus.IN_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        issue(8'd2, 8'd3, 1'b0, 16'd6);
        wait_done(4);
        release_result();

        guard = 0;
        while (sweep_finished < 3 && guard < 40000) begin
            @(negedge CLK);
            guard++;
        end
        check("sweep_complete", 32'(sweep_finished), 32'd3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Parameter sweep: 12x8 multipliers at 1, 4 and 8 bits per cycle.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SR  = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        localparam int LAT = 8 / SR;

        logic [19:0] sq[$];

        iter_partial_product_if #(.A_WIDTH(12), .B_WIDTH(8)) sbus ();

        iter_partial_product #(
            .A_WIDTH        (12),
            .B_WIDTH        (8),
            .BITS_PER_CYCLE (SR)
        ) sdut (
            .CLK   (CLK),
            .RST_N (sw_rst_n),
            .bus   (sbus.slave)
        );

        initial begin
            logic [11:0] a;
            logic [7:0]  b;
            int          c;

            sbus.IN_VALID  = 1'b0;
            sbus.OUT_READY = 1'b0;
            sbus.A         = '0;
            sbus.B         = '0;
`ifdef PP_SIGNED_EN
            sbus.SIGNED_MODE = 1'b0;
`endif
            @(posedge sw_rst_n);
            for (int i = 0; i < 1000; i++) begin
                a = 12'($urandom_range(0, 4095));
                b = 8'($urandom_range(0, 255));
                if (i == 0) begin
                    a = 12'hFFF;
                    b = 8'hFF;
                end
                @(negedge CLK);
                sbus.IN_VALID = 1'b1;
                sbus.A        = a;
                sbus.B        = b;
                sq.push_back(20'(a) * 20'(b));
                @(negedge CLK);
                sbus.IN_VALID = 1'b0;
                c = 0;
                while (!sbus.OUT_VALID && c < 64) begin
                    @(negedge CLK);
                    c++;
                end
                check($sformatf("sweep_r%0d_latency", SR), 32'(c), 32'(LAT));
                if (sq.size() == 0) begin
                    check($sformatf("sweep_r%0d_scoreboard", SR), 32'd0, 32'd1);
                end else begin
                    check($sformatf("sweep_r%0d_product", SR), 32'(sbus.P), 32'(sq.pop_front()));
                end
                sbus.OUT_READY = 1'b1;
                @(negedge CLK);
                sbus.OUT_READY = 1'b0;
            end
            sweep_finished++;
        end
    end

endmodule
